// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Groups the request/result signals of the bit-serial subtractor.
//   start, a, b, bin  : request side. The requester drives these.
//   diff, bout        : registered result of a - b - bin.
//   busy, done        : status. busy is high while bits are processed.
//                       done is a one-cycle pulse that marks a new result.
// Modports:
//   master : the requester, for example a testbench or a controller.
//   slave  : the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  diff, bout, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor that computes a - b - bin modulo 2^WIDTH.
// The block processes one bit per clock, LSB first, through a 1-bit full
// subtractor. Latency is WIDTH+1 cycles from the start edge to the done
// pulse. Back-to-back throughput is one operation per WIDTH+2 cycles.
// Ports:
//   clk : clock. All state changes on its rising edge.
//   rst : asynchronous, active-high reset. It clears all state and outputs.
//   bus : serial_subtractor_if.slave. It carries:
//         start/a/b/bin (in), diff/bout/busy/done (out).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One-bit full subtractor on the current LSBs of the operand shifters.
    logic             ai, bi, d_bit, br_next;
    logic [WIDTH-1:0] res_shifted;

    assign ai          = a_q[0];
    assign bi          = b_q[0];
    assign d_bit       = ai ^ bi ^ br_q;
    assign br_next     = (~ai & bi) | (~(ai ^ bi) & br_q);
    // Each result bit enters at the MSB. After WIDTH shifts, bit 0 has
    // reached position 0.
    assign res_shifted = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shifted;
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Outputs change only here, so partial results are
                    // never visible on diff/bout.
                    diff_d  = res_shifted;
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // busy and done are decoded straight from the state register. This lets
    // reset clear them at once, without waiting for a clock edge.
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [32:0] model(input int w, input int a, input int b, input int bin);
        int r;
        logic [32:0] res;
        r = a - b - bin;
        res = '0;
        res[31:0] = 32'(r) & ((32'd1 << w) - 32'd1);
        res[32] = (a < b + bin);
        return res;
    endfunction

    // One operation on the 8-bit DUT. It returns the result seen in the done
    // cycle, the cycles from the start edge to done, and the busy cycle count.
    // When noise is set, it drives random garbage on start/a/b/bin while busy.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit noise,
                       output logic [7:0] d, output logic bo, output int lat, output int busy_cnt);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (bus8.busy === 1'b1) busy_cnt++;
            if (noise && bus8.busy === 1'b1) begin
                bus8.start = 1'($urandom);
                bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus8.start = 1'b0;
        d = bus8.diff; bo = bus8.bout;
        check("busy_in_done", 32'(bus8.busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus8.done), 32'd0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output logic [3:0] d, output logic bo, output int lat);
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.bin = bin;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        lat = 0;
        while (bus4.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = bus4.diff; bo = bus4.bout;
    endtask

    initial begin
        vec_t vecs[9];
        logic [7:0] d;
        logic bo;
        logic [3:0] d4;
        logic bo4;
        int lat, bc, dones;
        logic [32:0] m;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        vecs[4] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_diff", 32'(bus8.diff), 32'd0);
        check("reset_bout", 32'(bus8.bout), 32'd0);
        check("reset_busy", 32'(bus8.busy), 32'd0);
        check("reset_done", 32'(bus8.done), 32'd0);
        rst = 1'b0;

        // Table-driven vectors. The last entry leaves diff=0xFE for the hold check.
        for (int i = 0; i < 9; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, d, bo, lat, bc);
            $display("vec %0d: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d lat=%0d busy=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat, bc);
            check("vec_diff", 32'(d), 32'(vecs[i].exp_diff));
            check("vec_bout", 32'(bo), 32'(vecs[i].exp_bout));
            check("vec_latency", 32'(lat), 32'd8);
            check("vec_busy_cycles", 32'(bc), 32'd8);
        end

        // diff must hold through idle cycles.
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) dones++;
            if (bus8.diff !== 8'hFE) check("hold_diff", 32'(bus8.diff), 32'hFE);
        end
        check("hold_diff_end", 32'(bus8.diff), 32'hFE);
        check("hold_no_done", 32'(dones), 32'd0);

        // Start pulses during SHIFT and DONE must be ignored.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (lat == 2) begin bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'hFF; end
            else bus8.start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("ignore_latency", 32'(lat), 32'd8);
        check("ignore_diff", 32'(bus8.diff), 32'h0F);
        check("ignore_bout", 32'(bus8.bout), 32'd0);
        bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'hFF;
        @(negedge clk);
        bus8.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
            @(negedge clk);
        end
        check("ignore_single_done", 32'(dones), 32'd0);
        $display("ignore seq: diff=%02h bout=%0d", bus8.diff, bus8.bout);

        // Asynchronous reset in SHIFT cycle 4 aborts the operation.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(bus8.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus8.busy), 32'd0);
        check("async_rst_done", 32'(bus8.done), 32'd0);
        check("async_rst_diff", 32'(bus8.diff), 32'd0);
        check("async_rst_bout", 32'(bus8.bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_diff", 32'(bus8.diff), 32'd0);
        op8(8'h03, 8'h05, 1'b0, 1'b0, d, bo, lat, bc);
        $display("post-reset op: a=03 b=05 -> diff=%02h bout=%0d", d, bo);
        check("post_rst_diff", 32'(d), 32'hFE);
        check("post_rst_bout", 32'(bo), 32'd1);
        check("post_rst_latency", 32'(lat), 32'd8);

        // Random operations with input noise during SHIFT.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            m = model(8, int'(ra), int'(rb), int'(rbin));
            op8(ra, rb, rbin, 1'b1, d, bo, lat, bc);
            $display("rand %0d: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d", i, ra, rb, rbin, d, bo);
            check("rand_diff", 32'(d), 32'(m[7:0]));
            check("rand_bout", 32'(bo), 32'(m[32]));
            check("rand_latency", 32'(lat), 32'd8);
        end

        // Exhaustive check of every (a, b, bin) for the 4-bit instance, back to back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    m = model(4, a, b, bi);
                    op4(4'(a), 4'(b), 1'(bi), d4, bo4, lat);
                    check("w4_diff", 32'(d4), 32'(m[3:0]));
                    check("w4_bout", 32'(bo4), 32'(m[32]));
                    check("w4_latency", 32'(lat), 32'd4);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and difference width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; sampled on the edge that accepts start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; sampled on the edge that accepts start.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in; sampled on the edge that accepts start.
REQ-008 The block SHALL have port diff, output, WIDTH bits: registered result a - b - bin, modulo 2^WIDTH.
REQ-009 The block SHALL have port bout, output, 1 bit: registered borrow-out; 1 when a < b + bin, unsigned.
REQ-010 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid diff/bout.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at an edge SHALL latch a, b, bin into internal shift/borrow registers, clear the bit counter and go to SHIFT; start=0 SHALL keep IDLE.
REQ-014 Each SHIFT cycle SHALL process one bit, LSB first, with a 1-bit full subtractor: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-015 Result bit d SHALL shift into an internal result register from the MSB end, so bit 0 is in position 0 after WIDTH shifts.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, the FSM SHALL go to DONE.
REQ-017 On entering DONE, diff and bout SHALL be loaded from the result register and final borrow, and done SHALL be 1 for exactly that one cycle.
REQ-018 DONE SHALL return to IDLE unconditionally after one cycle; start asserted during DONE SHALL be ignored.
REQ-019 Latency: for start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH; back-to-back throughput SHALL be one operation per WIDTH+2 cycles.
REQ-020 busy SHALL be 1 exactly in SHIFT and 0 in IDLE and DONE.
REQ-021 start, a, b and bin SHALL be ignored while busy=1; changing a/b/bin during SHIFT SHALL NOT affect the result.
REQ-022 diff and bout SHALL hold their last values unchanged from the DONE cycle until the next DONE; they SHALL NOT show partial results.
REQ-023 Width wrap-around: results SHALL be modulo 2^WIDTH with no saturation; bout alone flags underflow.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for clk, force state IDLE and clear counter, internal registers, diff, bout, busy and done to 0.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow, and diff/bout SHALL read 0.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 a=0x5A, b=0x3C, bin=0, start 1 cycle -> done after 9 edges, diff=0x1E, bout=0, busy high exactly 8 cycles.
REQ-028 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1.
REQ-029 a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0; diff stays 0xFE for 20 idle cycles with start=0.
REQ-030 Start 0x10-0x01, then pulse start with a=0x00, b=0xFF at SHIFT cycle 3 and during DONE -> single done, diff=0x0F, bout=0.
REQ-031 Assert rst asynchronously (mid-cycle) at SHIFT cycle 4 -> busy, done, diff, bout go 0 before next edge; no done pulse; the following start 0x03-0x05 gives diff=0xFE, bout=1.
REQ-032 Exhaustive check with WIDTH=4: all 512 (a,b,bin) combinations, back-to-back -> diff/bout match (a-b-bin) mod 16 and borrow each time.
